pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline. Combines hazard-detection output, EXE-stage branch resolution, data-memory busy, and a debug halt request into per-register freeze/flush/bubble controls.
- Tracks memory-wait duration with a sticky timeout flag.
- Provides a halt/resume handshake for the debug interface.
- Sits beside the hazard detection unit and drives the IF, IF/ID and ID/EX pipeline registers plus the back-end registers.

---
 rtl/pipeline_stall_controller_if.sv | 36 +++
 rtl/pipeline_stall_controller.sv | 128 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Control bundle between the pipeline front/back end and the stall controller.
// master = pipeline side (hazard/branch/memory/debug sources), slave = controller.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             hazard;
    logic             branch_taken;
    logic             mem_busy;
    logic             halt_req;

    logic             freeze_pc;
    logic             freeze_if_id;
    logic             freeze_back;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] mem_wait_cycles;

    modport master (
        output hazard, branch_taken, mem_busy, halt_req,
        input  freeze_pc, freeze_if_id, freeze_back, bubble_id_ex,
               flush_if_id, flush_id_ex, halted, mem_timeout,
               stall_cycles, flush_count, mem_wait_cycles
    );

    modport slave (
        input  hazard, branch_taken, mem_busy, halt_req,
        output freeze_pc, freeze_if_id, freeze_back, bubble_id_ex,
               flush_if_id, flush_id_ex, halted, mem_timeout,
               stall_cycles, flush_count, mem_wait_cycles
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with debug halt and memory-wait timeout.
// Define PERF_CNT_EN to build the stall/flush/mem-wait performance counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_stall_controller_if.slave  ctl
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX     = '1;
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic freeze_all;
    logic halt_go;
    logic freeze_pc, freeze_if_id, freeze_back;
    logic bubble_id_ex, flush_if_id, flush_id_ex;

    assign freeze_all = ctl.mem_busy | (state_q == HALT);
    // Halt waits for memory to finish and for a pending branch flush to complete.
    assign halt_go    = ctl.halt_req & ~ctl.mem_busy & ~ctl.branch_taken;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        freeze_back  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (freeze_all) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            freeze_back  = 1'b1;
        end else if (ctl.branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end else if (ctl.hazard) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (ctl.mem_busy)  state_d = MEM_WAIT;
                else if (halt_go)  state_d = HALT;
            end
            MEM_WAIT: begin
                if (halt_go)            state_d = HALT;
                else if (!ctl.mem_busy) state_d = RUN;
            end
            HALT: begin
                if (!ctl.halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (ctl.mem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == TIMEOUT_LAST) mem_timeout_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign ctl.freeze_pc    = freeze_pc;
    assign ctl.freeze_if_id = freeze_if_id;
    assign ctl.freeze_back  = freeze_back;
    assign ctl.bubble_id_ex = bubble_id_ex;
    assign ctl.flush_if_id  = flush_if_id;
    assign ctl.flush_id_ex  = flush_id_ex;
    assign ctl.halted       = (state_q == HALT);
    assign ctl.mem_timeout  = mem_timeout_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q, mem_wait_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q    <= '0;
            flush_count_q     <= '0;
            mem_wait_cycles_q <= '0;
        end else begin
            if (bubble_id_ex) stall_cycles_q    <= stall_cycles_q + 1'b1;
            if (flush_id_ex)  flush_count_q     <= flush_count_q + 1'b1;
            if (ctl.mem_busy) mem_wait_cycles_q <= mem_wait_cycles_q + 1'b1;
        end
    end

    assign ctl.stall_cycles    = stall_cycles_q;
    assign ctl.flush_count     = flush_count_q;
    assign ctl.mem_wait_cycles = mem_wait_cycles_q;
`else
    assign ctl.stall_cycles    = {CNT_W{1'b0}};
    assign ctl.flush_count     = {CNT_W{1'b0}};
    assign ctl.mem_wait_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed + randomized bench for pipeline_stall_controller against a cycle-level behavioural model.
// Honours PERF_CNT_EN the same way as the design build.
module tb_pipeline_stall_controller;
    localparam int MEM_TIMEOUT = 4;
    localparam int WAIT_W      = 3;
    localparam int CNT_W       = 32;

    logic clk;
    logic rst;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .WAIT_W      (WAIT_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: only what is architecturally visible.
    bit               m_halted;
    bit               m_timeout;
    int               m_run;
    logic [CNT_W-1:0] m_stall, m_flush, m_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_ctrl(input bit hz, br, mb);
        // {freeze_pc, freeze_if_id, freeze_back, bubble_id_ex, flush_if_id, flush_id_ex}
        if (mb || m_halted) return 6'b111000;
        if (br)             return 6'b000011;
        if (hz)             return 6'b110100;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        m_halted  = 0;
        m_timeout = 0;
        m_run     = 0;
        m_stall   = '0;
        m_flush   = '0;
        m_wait    = '0;
    endtask

    task automatic step(input string tag, input bit r, hz, br, mb, hr);
        logic [5:0] e;
        rst              = r;
        bus.hazard       = hz;
        bus.branch_taken = br;
        bus.mem_busy     = mb;
        bus.halt_req     = hr;
        #2;
        e = exp_ctrl(hz, br, mb);
        check({tag, ".ctrl"}, {bus.freeze_pc, bus.freeze_if_id, bus.freeze_back,
                               bus.bubble_id_ex, bus.flush_if_id, bus.flush_id_ex}, e);
        check({tag, ".halted"},      bus.halted, m_halted);
        check({tag, ".mem_timeout"}, bus.mem_timeout, m_timeout);
        check({tag, ".stall"},       bus.stall_cycles, m_stall);
        check({tag, ".flush"},       bus.flush_count, m_flush);
        check({tag, ".memwait"},     bus.mem_wait_cycles, m_wait);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_halted = m_halted ? hr : (hr && !mb && !br);
            if (mb) begin
                m_run++;
                if (m_run >= MEM_TIMEOUT) m_timeout = 1;
            end else begin
                m_run = 0;
            end
`ifdef PERF_CNT_EN
            if (e[2]) m_stall++;
            if (e[0]) m_flush++;
            if (mb)   m_wait++;
`endif
        end
        #1;
    endtask

    initial begin
        int mb_left;
        int hr_left;
        rst              = 1'b1;
        bus.hazard       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.halt_req     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        step("reset", 0, 0, 0, 0, 0);

        // Hazard bubble for two cycles.
        step("hz1", 0, 1, 0, 0, 0);
        step("hz2", 0, 1, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
        check("stall_eq_2", bus.stall_cycles, 2);
`endif

        // Branch wins over hazard.
        step("hz_br", 0, 1, 1, 0, 0);

        // Branch held across a memory wait.
        step("mb_br1", 0, 0, 1, 1, 0);
        step("mb_br2", 0, 0, 1, 1, 0);
        step("mb_br3", 0, 0, 1, 1, 0);
        step("br_rel", 0, 0, 1, 0, 0);

        // Timeout after MEM_TIMEOUT consecutive busy cycles; sticky afterwards.
        step("to1", 0, 0, 0, 1, 0);
        step("to2", 0, 0, 0, 1, 0);
        step("to3", 0, 0, 0, 1, 0);
        step("to4", 0, 0, 0, 1, 0);
        check("timeout_set", bus.mem_timeout, 1'b1);
        step("to_idle1", 0, 0, 0, 0, 0);
        step("to_idle2", 0, 1, 0, 0, 0);
        check("timeout_sticky", bus.mem_timeout, 1'b1);

        // Halt deferred by memory busy, then resume.
        step("hr_mb1", 0, 0, 0, 1, 1);
        step("hr_mb2", 0, 0, 0, 1, 1);
        check("no_halt_yet", bus.halted, 1'b0);
        step("hr_go", 0, 1, 0, 0, 1);
        step("hr_hold", 0, 0, 0, 0, 1);
        step("hr_drop", 0, 1, 0, 0, 0);
        step("resumed", 0, 1, 0, 0, 0);

        // Halt deferred by a branch.
        step("hr_br", 0, 0, 1, 0, 1);
        step("hr_br2", 0, 0, 0, 0, 1);
        step("hr_br3", 0, 0, 0, 0, 1);

        // Reset while halted with the timeout flag set.
        step("rst_halt", 1, 0, 0, 1, 1);
        step("post_rst", 0, 0, 0, 0, 0);
        check("post_rst_halted", bus.halted, 1'b0);
        check("post_rst_timeout", bus.mem_timeout, 1'b0);

        // Randomized traffic with bursty mem_busy / halt_req and rare resets.
        mb_left = 0;
        hr_left = 0;
        for (int i = 0; i < 2000; i++) begin
            bit r, hz, br;
            if (mb_left == 0 && $urandom_range(0, 7) == 0) mb_left = $urandom_range(1, 9);
            if (hr_left == 0 && $urandom_range(0, 15) == 0) hr_left = $urandom_range(1, 6);
            r  = ($urandom_range(0, 149) == 0);
            hz = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 4) == 0);
            step("rand", r, hz, br, mb_left > 0, hr_left > 0);
            if (mb_left > 0) mb_left--;
            if (hr_left > 0) hr_left--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
